// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops, multi-cycle
// shifts (one bit per cycle) and a shift-add unsigned multiply (low half).
module alu_seq #(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 4,
  parameter int SSIZE  = $clog2(DSIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] op,
  input  logic [DSIZE-1:0]  data_a,
  input  logic [DSIZE-1:0]  data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  f,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v
);

  localparam int CW  = SSIZE + 1;
  localparam int MSB = DSIZE - 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sop_q;
  logic [DSIZE-1:0]   a_q;
  logic [2*DSIZE-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic [DSIZE-1:0]   f_q;
  logic               n_q, z_q, c_q, v_q;

  logic accept, start_exec;

  assign accept     = in_valid & in_ready;
  assign start_exec = (op[3:2] == 2'b11) &&
                      ((op[1:0] == 2'b11) || (data_b[SSIZE-1:0] != '0));

  // Single-cycle result, evaluated on the operands being accepted.
  logic [DSIZE-1:0] opnd2, res_f;
  logic             cin, res_c, res_v;
  logic [DSIZE:0]   sum;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    opnd2 = '0;
    cin   = 1'b0;
    res_f = data_a;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op[2:0])
      3'b001:  cin = 1'b1;
      3'b010:  opnd2 = ~data_b;
      3'b011:  begin opnd2 = ~data_b; cin = 1'b1; end
      3'b100:  opnd2 = data_b;
      3'b101:  begin opnd2 = data_b; cin = 1'b1; end
      3'b111:  opnd2 = '1;
      default: ;
    endcase
    sum = {1'b0, data_a} + {1'b0, opnd2} + {{DSIZE{1'b0}}, cin};
    if (!op[3]) begin
      if (op[2:0] == 3'b000 || op[2:0] == 3'b110) begin
        res_f = op[1] ? data_b : data_a;
      end else begin
        res_f = sum[MSB:0];
        res_c = sum[DSIZE];
        res_v = (data_a[MSB] == opnd2[MSB]) && (sum[MSB] != data_a[MSB]);
      end
    end else if (!op[2]) begin
      case (op[1:0])
        2'b00:   res_f = data_a & data_b;
        2'b01:   res_f = data_a | data_b;
        2'b10:   res_f = data_a ^ data_b;
        default: res_f = ~data_a;
      endcase
    end
  end

  // One iteration of the running shift or shift-add multiply.
  logic [2*DSIZE-1:0] step_prod;
  logic [DSIZE:0]     mul_sum;
  logic               step_c;

  always_comb begin
    mul_sum = {1'b0, prod_q[2*DSIZE-1:DSIZE]} +
              {1'b0, (prod_q[0] ? a_q : {DSIZE{1'b0}})};
    case (sop_q)
      2'b00: begin
        step_prod = {prod_q[2*DSIZE-1:DSIZE], prod_q[DSIZE-2:0], 1'b0};
        step_c    = prod_q[MSB];
      end
      2'b01: begin
        step_prod = {prod_q[2*DSIZE-1:DSIZE], 1'b0, prod_q[MSB:1]};
        step_c    = prod_q[0];
      end
      2'b10: begin
        step_prod = {prod_q[2*DSIZE-1:DSIZE], prod_q[MSB], prod_q[MSB:1]};
        step_c    = prod_q[0];
      end
      default: begin
        step_prod = {mul_sum, prod_q[MSB:1]};
        step_c    = |mul_sum;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                                 state_d = start_exec ? EXEC : DONE;
    else if (state_q == EXEC && cnt_q == CW'(1)) state_d = DONE;
    else if (state_q == DONE && out_ready)       state_d = IDLE;
  end

  always_comb begin
    out_valid = (state_q == DONE);
    in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE && out_ready));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other one.
    if (rst) begin
      sop_q  <= '0;
      a_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      f_q    <= '0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
    end else if (accept) begin
      sop_q <= op[1:0];
      a_q   <= data_a;
      if (start_exec) begin
        prod_q <= {{DSIZE{1'b0}}, (op[1:0] == 2'b11) ? data_b : data_a};
        cnt_q  <= (op[1:0] == 2'b11) ? CW'(DSIZE) : {1'b0, data_b[SSIZE-1:0]};
      end else begin
        f_q <= res_f;
        n_q <= res_f[MSB];
        z_q <= (res_f == '0);
        c_q <= res_c;
        v_q <= res_v;
      end
    end else if (state_q == EXEC) begin
      prod_q <= step_prod;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        f_q <= step_prod[MSB:0];
        n_q <= step_prod[MSB];
        z_q <= (step_prod[MSB:0] == '0);
        c_q <= (sop_q == 2'b11) ? (|step_prod[2*DSIZE-1:DSIZE]) : step_c;
        v_q <= 1'b0;
      end
    end
  end

  assign f = f_q;
  assign n = n_q;
  assign z = z_q;
  assign c = c_q;
  assign v = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: accepted ops push expected results from an
// arithmetic reference model; an independent monitor checks every output.
module tb_alu_seq;

  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [D-1:0] a = '0;
  logic [D-1:0] b = '0;
  logic         in_ready, out_valid, n, z, c, v;
  logic [D-1:0] f;

  alu_seq #(.DSIZE(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data_a(a), .data_b(b), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .n(n), .z(z), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [D-1:0] f;
    logic         n, z, c, v;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  bit   head_seen = 0;
  bit   rand_ready = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
  endtask

  // Reference model: plain integer arithmetic on the opcode semantics.
  function automatic exp_t model(logic [3:0] o, logic [D-1:0] x, logic [D-1:0] y);
    exp_t   e;
    longint ua, ub, sa, so2, op2, cin, s, ss, t;
    int     amt;
    bit     pass_op;
    ua = longint'(x);
    ub = longint'(y);
    sa = x[D-1] ? ua - 65536 : ua;
    amt = int'(y[3:0]);
    e.f = x; e.c = 0; e.v = 0; e.lat = 1; e.acc = 0;
    if (!o[3]) begin
      pass_op = 0; op2 = 0; cin = 0;
      case (o[2:0])
        3'd0: pass_op = 1;
        3'd1: cin = 1;
        3'd2: op2 = (~ub) & 'hFFFF;
        3'd3: begin op2 = (~ub) & 'hFFFF; cin = 1; end
        3'd4: op2 = ub;
        3'd5: begin op2 = ub; cin = 1; end
        3'd6: begin pass_op = 1; e.f = y; end
        default: op2 = 'hFFFF;
      endcase
      if (!pass_op) begin
        s   = ua + op2 + cin;
        e.f = s[D-1:0];
        e.c = s[D];
        so2 = (op2 >= 32768) ? op2 - 65536 : op2;
        ss  = sa + so2 + cin;
        e.v = (ss > 32767) || (ss < -32768);
      end
    end else if (!o[2]) begin
      case (o[1:0])
        2'd0: e.f = x & y;
        2'd1: e.f = x | y;
        2'd2: e.f = x ^ y;
        default: e.f = ~x;
      endcase
    end else if (o[1:0] != 2'b11) begin
      e.lat = amt + 1;
      case (o[1:0])
        2'd0: begin
          t = ua << amt; e.f = t[D-1:0];
          e.c = (amt != 0) && (((ua >> (D - amt)) & 1) != 0);
        end
        2'd1: begin
          t = ua >> amt; e.f = t[D-1:0];
          e.c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
        end
        default: begin
          t = sa >>> amt; e.f = t[D-1:0];
          e.c = (amt != 0) && (((sa >>> (amt - 1)) & 1) != 0);
        end
      endcase
    end else begin
      t = ua * ub;
      e.f = t[D-1:0];
      e.c = (t >> D) != 0;
      e.lat = D + 1;
    end
    e.n = e.f[D-1];
    e.z = (e.f == 0);
    return e;
  endfunction

  task automatic issue(logic [3:0] o, logic [D-1:0] x, logic [D-1:0] y);
    bit   got = 0;
    int   acc_c = 0;
    exp_t e;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; acc_c = cyc + 1; end
      @(posedge clk);
    end
    if (got) begin
      e = model(o, x, y);
      e.acc = acc_c;
      sb.push_back(e);
    end else begin
      check("accept_timeout", 0, 1);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      head_seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        if (!head_seen) begin
          check("latency", cyc - sb[0].acc + 1, sb[0].lat);
          head_seen = 1;
        end
        check("f", f, sb[0].f);
        check("nzcv", {n, z, c, v}, {sb[0].n, sb[0].z, sb[0].c, sb[0].v});
        if (!out_ready) check("in_ready_hold", in_ready, 0);
        else begin
          void'(sb.pop_front());
          head_seen = 0;
        end
      end
    end else if (sb.size() != 0) begin
      check("in_ready_busy", in_ready, 0);
    end
  end

  always @(posedge clk) begin
    if (rand_ready) #1 out_ready = ($urandom_range(3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct { logic [3:0] o; logic [D-1:0] x, y; } vec_t;
  vec_t dir[$];

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_f", f, 0);
    check("rst_flags", {n, z, c, v}, 0);
    @(posedge clk) #1 rst = 1'b0;

    dir = '{'{4'h4, 16'h7FFF, 16'h0001}, '{4'h3, 16'h0005, 16'h0005},
            '{4'h7, 16'h8000, 16'h0000}, '{4'hC, 16'h8001, 16'h0003},
            '{4'hD, 16'h8001, 16'h0001}, '{4'hE, 16'h8000, 16'h0004},
            '{4'hC, 16'h1234, 16'h0000}, '{4'hE, 16'hA5A5, 16'h0000},
            '{4'hF, 16'h0100, 16'h0100}, '{4'hF, 16'h00FF, 16'h0003},
            '{4'h0, 16'h0000, 16'h1234}, '{4'h6, 16'h1234, 16'h8000},
            '{4'h1, 16'hFFFF, 16'h0000}, '{4'h2, 16'h8000, 16'h0001},
            '{4'h5, 16'hFFFF, 16'h0000}, '{4'hB, 16'h00FF, 16'h0000},
            '{4'hD, 16'hFFFF, 16'h000F}, '{4'hC, 16'hFFFF, 16'h000F}};
    foreach (dir[i]) begin
      issue(dir[i].o, dir[i].x, dir[i].y);
      drain();
    end

    // Back-to-back single-cycle ops at full rate.
    for (int i = 0; i < 12; i++) issue(4'(i), 16'($urandom), 16'($urandom));
    drain();

    // Consumer stalls in DONE, then a queued AND is taken the same cycle.
    out_ready = 1'b0;
    issue(4'h4, 16'h1234, 16'h1111);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk) #1 out_ready = 1'b1;
    issue(4'h8, 16'hF0F0, 16'h0FF0);
    drain();

    // Reset in the middle of a multiply.
    issue(4'hF, 16'h1234, 16'h0567);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_f", f, 0);
    check("abort_flags", {n, z, c, v}, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk) #1;
    issue(4'h5, 16'h0003, 16'h0004);
    drain();

    // Randomized traffic with random back-pressure and idle gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [D-1:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(3) == 0) ? 16'($urandom_range(15)) : 16'($urandom);
      if ($urandom_range(3) == 0) @(posedge clk) #1;
      issue(4'($urandom_range(15)), ra, rb);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk) #2 out_ready = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational ALU.
- Keeps the 8 arithmetic and 4 logic ops and adds multi-cycle shifts (SHL/SHR/ASR) and an unsigned multiply (low half).
- Registers the result with a full n/z/c/v flag set behind valid/ready on both sides.
- Sits between the datapath register file and the writeback stage.

Parameters:
- DSIZE, 16, operand/result width in bits (>=4, power of 2).
- OPSIZE, 4, opcode width; the encoding below is defined for 4 only.
- SSIZE, $clog2(DSIZE), width of the shift amount taken from data_b[SSIZE-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted when in_valid & in_ready at clk edge
- op  input  OPSIZE  opcode, sampled on accept
- data_a  input  DSIZE  operand A, sampled on accept
- data_b  input  DSIZE  operand B (shift amount for shifts), sampled on accept
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result when out_valid & out_ready
- f  output  DSIZE  registered result
- n  output  1  negative flag
- z  output  1  zero flag
- c  output  1  carry/borrow/shift-out/mul-overflow flag
- v  output  1  signed overflow flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, out_valid=0, f=0, n=z=c=v=0. in_ready=0 while rst=1. Reset mid-operation aborts it with no output.
- FSM states: IDLE, EXEC, DONE.
  - in_ready = (IDLE) | (DONE & out_ready). The combinational out_ready->in_ready path is intentional.
  - Accept, single-cycle op -> DONE next edge (latency 1).
  - Accept, shift/mul -> EXEC.
  - EXEC -> DONE when the iteration counter expires.
  - DONE with out_ready & !in_valid -> IDLE.
  - DONE with out_ready & in_valid -> accept new op (back-to-back, 1 op/cycle for single-cycle ops).
- out_valid=1 exactly in DONE. f and flags are held stable while out_valid & !out_ready.
- Arithmetic ops (op[3]=0), computed in DSIZE+1 bits:
  - 0000 A
  - 0001 A+1
  - 0010 A+~B
  - 0011 A+~B+1
  - 0100 A+B
  - 0101 A+B+1
  - 0110 B
  - 0111 A-1 (computed as A + all-ones)
- Arithmetic flags:
  - c = bit DSIZE of the sum.
  - v = (sign of A == sign of the second operand) & (sign of f != sign of A).
  - The second operand is ~B, B, 0 (A+1) or all-ones (A-1).
  - Pass ops (0000, 0110): c=v=0.
- Logic ops, c=v=0:
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
- Shift ops, one bit per EXEC cycle, amt = data_b[SSIZE-1:0]:
  - 1100 SHL, 1101 SHR (logical), 1110 ASR.
  - Latency amt+1 cycles from accept to out_valid. amt=0 -> latency 1, f=A, c=0.
  - c = last bit shifted out; v=0.
- MUL (1111): shift-add over DSIZE EXEC cycles, latency DSIZE+1.
  - f = low DSIZE bits of A*B (unsigned).
  - c = 1 if the high DSIZE bits are nonzero; v=0.
- All ops: n = f[DSIZE-1], z = (f==0).
- Operands and op are captured on accept. Input changes during EXEC/DONE have no effect.

Test Plan (DSIZE=16):
- ADD 0x7FFF+0x0001, op 0100 -> f=0x8000, n=1 z=0 c=0 v=1; out_valid 1 cycle after accept.
- SUB 0x0005, 0x0005, op 0011 -> f=0x0000, z=1 c=1 v=0. op 0111 with A=0x8000 -> f=0x7FFF, v=1 c=1.
- Shifts:
  - SHL 0x8001 by 3 -> f=0x0008, c=0, out_valid 4 cycles after accept, in_ready=0 meanwhile.
  - SHR 0x8001 by 1 -> f=0x4000, c=1.
  - ASR 0x8000 by 4 -> f=0xF800, n=1.
  - Shift by 0 -> f=A, latency 1.
- MUL 0x0100*0x0100 -> f=0x0000, z=1 c=1, latency 17. MUL 0x00FF*0x0003 -> f=0x02FD, c=0.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> f/flags stable, in_ready=0. Then out_ready=1 with a queued AND 0xF0F0&0x0FF0 -> accepted the same cycle, f=0x00F0 next cycle.
- Assert rst for 1 cycle at MUL cycle 8 -> next cycle IDLE, out_valid=0, f=0, flags 0. A new op is accepted once rst is deasserted.
